neptune_measure_sequencer: RTL and testbench

// - Sequences frequency measurement for the Neptune tuner: synchronises the raw pulse

---
 rtl/neptune_pkg.sv | 19 +
 rtl/neptune_measure_sequencer_if.sv | 27 ++
 rtl/neptune_pulse_sync.sv | 30 +++
 rtl/neptune_measure_sequencer.sv | 167 ++++++++++++++++
 tb/tb_neptune_measure_sequencer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/neptune_pkg.sv
// Shared types and helpers for the Neptune tuner measurement sequencer.
// The window length scales by powers of two with the configuration select.
package neptune_pkg;

    localparam int CFG_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_GATE,
        ST_HANDOFF,
        ST_HOLDOFF
    } state_e;

    function automatic int unsigned win_len(input int unsigned base, input logic [CFG_W-1:0] cfg);
        return base << cfg;
    endfunction

endpackage

// File: rtl/neptune_measure_sequencer_if.sv
// Result handshake between the measurement sequencer and the note classifier/display.
interface neptune_measure_sequencer_if #(
    parameter int COUNT_W = 12
);
    logic               meas_valid;
    logic               meas_ready;
    logic [COUNT_W-1:0] meas_count;
    logic               meas_overflow;
    logic               meas_no_signal;

    modport master (
        output meas_valid,
        output meas_count,
        output meas_overflow,
        output meas_no_signal,
        input  meas_ready
    );

    modport slave (
        input  meas_valid,
        input  meas_count,
        input  meas_overflow,
        input  meas_no_signal,
        output meas_ready
    );

endinterface

// File: rtl/neptune_pulse_sync.sv
// Two-flop synchroniser plus registered rising-edge detector for the raw pulse pin.
// A pin rise shows up as a one-cycle edge_pulse exactly three clocks later.
module neptune_pulse_sync (
    input  logic clk,
    input  logic reset,
    input  logic pulse_in,
    output logic edge_pulse
);

    logic [2:0] sync_q, sync_d;
    logic       edge_q, edge_d;

    always_comb begin
        sync_d = {sync_q[1:0], pulse_in};
        edge_d = sync_q[1] & ~sync_q[2];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            edge_q <= edge_d;
        end
    end

    assign edge_pulse = edge_q;

endmodule

// File: rtl/neptune_measure_sequencer.sv
// Frequency measurement sequencer: arms on a pulse edge, counts edges over a scaled
// gate window and hands the result to the decoder through a valid/ready interface.
module neptune_measure_sequencer
    import neptune_pkg::*;
#(
    parameter int BASE_WINDOW = 1000,
    parameter int WIN_W       = 14,
    parameter int COUNT_W     = 12,
    parameter int HOLDOFF     = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               enable,
    input  logic [CFG_W-1:0]                   clk_config,
    input  logic                               pulse_in,
    neptune_measure_sequencer_if.master        meas,
    output logic                               window_active,
    output logic                               busy
);

    localparam logic [COUNT_W-1:0] CNT_MAX   = '1;
    localparam logic [WIN_W-1:0]   HOLD_LAST = WIN_W'(HOLDOFF - 1);

    state_e             state_q, state_d;
    logic [CFG_W-1:0]   cfg_q, cfg_d;
    logic [WIN_W-1:0]   timer_q, timer_d;
    logic [WIN_W-1:0]   win_last;
    logic [COUNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic               ovf_q, ovf_d, ovf_inc;
    logic [COUNT_W-1:0] res_count_q, res_count_d;
    logic               res_ovf_q, res_ovf_d;
    logic               res_nosig_q, res_nosig_d;
    logic               arm_entry;
    logic               edge_pulse;

    neptune_pulse_sync u_pulse_sync (
        .clk        (clk),
        .reset      (reset),
        .pulse_in   (pulse_in),
        .edge_pulse (edge_pulse)
    );

    // Saturating edge count; the overflow flag sticks once an edge arrives at full scale.
    always_comb begin
        win_last = WIN_W'(win_len(BASE_WINDOW, cfg_q) - 32'd1);
        cnt_inc  = cnt_q;
        ovf_inc  = ovf_q;
        if (edge_pulse) begin
            if (cnt_q == CNT_MAX) begin
                ovf_inc = 1'b1;
            end else begin
                cnt_inc = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        timer_d     = timer_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        res_count_d = res_count_q;
        res_ovf_d   = res_ovf_q;
        res_nosig_d = res_nosig_q;
        arm_entry   = 1'b0;

        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d   = ST_ARM;
                    arm_entry = 1'b1;
                end
                ST_ARM: begin
                    if (edge_pulse) begin
                        state_d = ST_GATE;
                        timer_d = '0;
                    end else if (timer_q == win_last) begin
                        state_d     = ST_HANDOFF;
                        res_count_d = '0;
                        res_ovf_d   = 1'b0;
                        res_nosig_d = 1'b1;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                ST_GATE: begin
                    // A scale change mid-window makes the count meaningless, so drop it.
                    if (clk_config != cfg_q) begin
                        state_d = ST_HOLDOFF;
                        timer_d = '0;
                    end else begin
                        cnt_d = cnt_inc;
                        ovf_d = ovf_inc;
                        if (timer_q == win_last) begin
                            state_d     = ST_HANDOFF;
                            res_count_d = cnt_inc;
                            res_ovf_d   = ovf_inc;
                            res_nosig_d = 1'b0;
                        end else begin
                            timer_d = timer_q + 1'b1;
                        end
                    end
                end
                ST_HANDOFF: begin
                    if (meas.meas_ready) begin
                        state_d = ST_HOLDOFF;
                        timer_d = '0;
                    end
                end
                ST_HOLDOFF: begin
                    if (timer_q == HOLD_LAST) begin
                        state_d   = ST_ARM;
                        arm_entry = 1'b1;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (arm_entry) begin
            cfg_d       = clk_config;
            timer_d     = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            res_count_d = '0;
            res_ovf_d   = 1'b0;
            res_nosig_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cfg_q       <= '0;
            timer_q     <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            res_count_q <= '0;
            res_ovf_q   <= 1'b0;
            res_nosig_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            timer_q     <= timer_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            res_count_q <= res_count_d;
            res_ovf_q   <= res_ovf_d;
            res_nosig_q <= res_nosig_d;
        end
    end

    assign meas.meas_valid     = (state_q == ST_HANDOFF);
    assign meas.meas_count     = res_count_q;
    assign meas.meas_overflow  = res_ovf_q;
    assign meas.meas_no_signal = res_nosig_q;
    assign window_active       = (state_q == ST_GATE);
    assign busy                = (state_q != ST_IDLE);

endmodule

// File: tb/tb_neptune_measure_sequencer.sv
// Directed bench for the measurement sequencer: a 100-cycle base window instance with a
// 12-bit count, and a 4-bit count instance used to drive the counter into saturation.
module tb_neptune_measure_sequencer;

    logic       clk;
    logic       reset;
    logic       enableA, enableB;
    logic [1:0] cfgA, cfgB;
    logic       pulseA, pulseB;
    logic       winA, winB;
    logic       busyA, busyB;
    int         periodA, periodB;
    int         checks;
    int         failures;
    int         winCycles;
    int         gap;

    neptune_measure_sequencer_if #(.COUNT_W(12)) busA ();
    neptune_measure_sequencer_if #(.COUNT_W(4))  busB ();

    neptune_measure_sequencer #(
        .BASE_WINDOW (100),
        .WIN_W       (14),
        .COUNT_W     (12),
        .HOLDOFF     (16)
    ) dutA (
        .clk           (clk),
        .reset         (reset),
        .enable        (enableA),
        .clk_config    (cfgA),
        .pulse_in      (pulseA),
        .meas          (busA.master),
        .window_active (winA),
        .busy          (busyA)
    );

    neptune_measure_sequencer #(
        .BASE_WINDOW (100),
        .WIN_W       (14),
        .COUNT_W     (4),
        .HOLDOFF     (16)
    ) dutB (
        .clk           (clk),
        .reset         (reset),
        .enable        (enableB),
        .clk_config    (cfgB),
        .pulse_in      (pulseB),
        .meas          (busB.master),
        .window_active (winB),
        .busy          (busyB)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Square-wave pulse sources; a period of zero holds the pin low.
    initial begin
        int phA;
        int phB;
        phA = 0;
        phB = 0;
        pulseA = 1'b0;
        pulseB = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (periodA > 0) begin
                phA = (phA + 1) % periodA;
                pulseA = (phA < periodA / 2);
            end else begin
                phA = 0;
                pulseA = 1'b0;
            end
            if (periodB > 0) begin
                phB = (phB + 1) % periodB;
                pulseB = (phB < periodB / 2);
            end else begin
                phB = 0;
                pulseB = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [1:0] cfg, input logic rdy);
        @(negedge clk);
        enableA         = en;
        cfgA            = cfg;
        busA.meas_ready = rdy;
    endtask

    task automatic waitValid(input bit useB, input int budget, output int wins);
        bit seen;
        seen = 1'b0;
        wins = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (useB ? busB.meas_valid : busA.meas_valid) seen = 1'b1;
            else if (useB ? winB : winA) wins++;
        end
        checkOutput("valid_timeout", 32'(seen), 32'd1);
    endtask

    task automatic waitWindow(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (winA) seen = 1'b1;
        end
        checkOutput("window_timeout", 32'(seen), 32'd1);
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        reset           = 1'b1;
        enableA         = 1'b0;
        enableB         = 1'b0;
        cfgA            = 2'd0;
        cfgB            = 2'd0;
        periodA         = 10;
        periodB         = 0;
        busA.meas_ready = 1'b0;
        busB.meas_ready = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("rst_valid", 32'(busA.meas_valid), 32'd0);
        checkOutput("rst_count", 32'(busA.meas_count), 32'd0);
        checkOutput("rst_ovf", 32'(busA.meas_overflow), 32'd0);
        checkOutput("rst_nosig", 32'(busA.meas_no_signal), 32'd0);
        checkOutput("rst_window", 32'(winA), 32'd0);
        checkOutput("rst_busy", 32'(busyA), 32'd0);
        reset = 1'b0;

        $display("[TB] cfg=0, period 10");
        applyStimulus(1'b1, 2'd0, 1'b0);
        waitValid(1'b0, 2000, winCycles);
        checkOutput("c0_count", 32'(busA.meas_count), 32'd10);
        checkOutput("c0_ovf", 32'(busA.meas_overflow), 32'd0);
        checkOutput("c0_nosig", 32'(busA.meas_no_signal), 32'd0);
        checkOutput("c0_window", 32'(winCycles), 32'd100);

        $display("[TB] hold ready low, then accept and time the no-signal run");
        repeat (50) @(negedge clk);
        checkOutput("stall_valid", 32'(busA.meas_valid), 32'd1);
        checkOutput("stall_count", 32'(busA.meas_count), 32'd10);
        periodA = 0;
        applyStimulus(1'b1, 2'd1, 1'b1);
        applyStimulus(1'b1, 2'd1, 1'b0);
        checkOutput("accept_valid", 32'(busA.meas_valid), 32'd0);
        checkOutput("holdoff_busy", 32'(busyA), 32'd1);
        gap = 1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (busA.meas_valid) break;
            gap++;
        end
        checkOutput("nosig_gap", 32'(gap), 32'd216);
        checkOutput("nosig_valid", 32'(busA.meas_valid), 32'd1);
        checkOutput("nosig_count", 32'(busA.meas_count), 32'd0);
        checkOutput("nosig_flag", 32'(busA.meas_no_signal), 32'd1);
        checkOutput("nosig_ovf", 32'(busA.meas_overflow), 32'd0);

        $display("[TB] cfg=2, period 10");
        applyStimulus(1'b1, 2'd2, 1'b1);
        applyStimulus(1'b1, 2'd2, 1'b0);
        periodA = 10;
        waitValid(1'b0, 3000, winCycles);
        checkOutput("c2_count", 32'(busA.meas_count), 32'd40);
        checkOutput("c2_window", 32'(winCycles), 32'd400);
        checkOutput("c2_nosig", 32'(busA.meas_no_signal), 32'd0);
        checkOutput("c2_ovf", 32'(busA.meas_overflow), 32'd0);

        $display("[TB] config change during gate");
        applyStimulus(1'b1, 2'd2, 1'b1);
        applyStimulus(1'b1, 2'd2, 1'b0);
        waitWindow(1000);
        repeat (50) @(negedge clk);
        applyStimulus(1'b1, 2'd0, 1'b0);
        repeat (5) @(negedge clk);
        checkOutput("abort_valid", 32'(busA.meas_valid), 32'd0);
        checkOutput("abort_window", 32'(winA), 32'd0);
        checkOutput("abort_busy", 32'(busyA), 32'd1);
        waitValid(1'b0, 2000, winCycles);
        checkOutput("rearm_count", 32'(busA.meas_count), 32'd10);
        checkOutput("rearm_window", 32'(winCycles), 32'd100);

        $display("[TB] enable low with result pending, then mid-gate");
        applyStimulus(1'b0, 2'd0, 1'b0);
        @(negedge clk);
        checkOutput("dis_valid", 32'(busA.meas_valid), 32'd0);
        checkOutput("dis_busy", 32'(busyA), 32'd0);
        applyStimulus(1'b1, 2'd0, 1'b0);
        waitWindow(1000);
        repeat (20) @(negedge clk);
        applyStimulus(1'b0, 2'd0, 1'b0);
        @(negedge clk);
        checkOutput("disgate_window", 32'(winA), 32'd0);
        checkOutput("disgate_busy", 32'(busyA), 32'd0);

        $display("[TB] async reset during handoff");
        applyStimulus(1'b1, 2'd0, 1'b0);
        waitValid(1'b0, 2000, winCycles);
        checkOutput("prerst_count", 32'(busA.meas_count), 32'd10);
        #2 reset = 1'b1;
        #1;
        checkOutput("arst_valid", 32'(busA.meas_valid), 32'd0);
        checkOutput("arst_count", 32'(busA.meas_count), 32'd0);
        checkOutput("arst_busy", 32'(busyA), 32'd0);
        checkOutput("arst_window", 32'(winA), 32'd0);
        @(negedge clk);
        reset   = 1'b0;
        enableA = 1'b0;
        periodA = 0;

        $display("[TB] 4-bit count saturation, period 2");
        @(negedge clk);
        periodB = 2;
        cfgB    = 2'd0;
        enableB = 1'b1;
        waitValid(1'b1, 2000, winCycles);
        checkOutput("sat_count", 32'(busB.meas_count), 32'd15);
        checkOutput("sat_ovf", 32'(busB.meas_overflow), 32'd1);
        checkOutput("sat_nosig", 32'(busB.meas_no_signal), 32'd0);
        checkOutput("sat_window", 32'(winCycles), 32'd100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
